// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the zero-crossing frequency meter.
//   fsm_state_e  : conversion FSM states
//   bcd_digit_t  : one packed BCD digit
//   MAX_DISPLAY  : largest value the four-digit display can show
//   BCD_DIGITS   : number of BCD digits produced
//   dd_adjust()  : double-dabble "add 3 if >= 5" step for one digit
package freq_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScale,
        StConv,
        StPub
    } fsm_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned MAX_DISPLAY = 9999;
    localparam int unsigned BCD_DIGITS  = 4;

    function automatic bcd_digit_t dd_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// A start pulse loads i_bin and performs the first shift; each following
// cycle performs one more shift, BIN_W shifts in total. o_done is high for
// the single cycle in which o_bcd holds the finished result.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_start : load i_bin and begin conversion
//   i_bin   : binary input (must be <= MAX_DISPLAY)
//   o_done  : conversion finished, o_bcd valid this cycle
//   o_bcd   : BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [BIN_W-1:0]        i_bin,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] r_sr;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            w_adj[4*i +: 4] = dd_adjust(r_bcd[4*i +: 4]);
        end
    end

    assign o_done = r_active && (r_cnt == CNT_W'(BIN_W));
    assign o_bcd  = r_bcd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr     <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            // Adjusting an all-zero BCD field is a no-op, so the first shift
            // can be folded into the load.
            r_bcd    <= {{(BCD_W-1){1'b0}}, i_bin[BIN_W-1]};
            r_sr     <= i_bin << 1;
            r_cnt    <= CNT_W'(1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_bcd <= {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
                r_sr  <= r_sr << 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Zero-crossing frequency meter. Decimates the mic sample bus with an
// internal strobe, counts hysteresis-qualified rising crossings over a gate
// window of GATE_SAMPLES samples, then scales, clamps to 9999, converts to
// BCD and publishes the result.
// Optional feature macro: FREQ_METER_AUTOTHRESH_EN
//   defined   : threshold adapts to the midpoint of each window's min/max
//   undefined : threshold is thr_in
// Ports:
//   CLK100MHZ   : system clock
//   reset       : synchronous active-high reset
//   mic_in      : sample bus, taken on the sample strobe only
//   thr_in      : fixed threshold (ignored when the macro is defined)
//   freq        : last published frequency
//   dig_0..3    : BCD ones/tens/hundreds/thousands
//   freq_valid  : one-cycle pulse on publish
//   overflow    : last published result was saturated
//   busy        : conversion in progress
//   thr_out     : threshold currently in use
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = 12,
    parameter int unsigned SAMPLE_DIV   = 5000,
    parameter int unsigned GATE_SAMPLES = 10000,
    parameter int unsigned SCALE        = 2,
    parameter int unsigned FREQ_OFFSET  = 0,
    parameter int unsigned HYST         = 64,
    parameter int unsigned THR_DEFAULT  = 2150,
    parameter int unsigned MIN_SWING    = 256,
    parameter int unsigned FREQ_W       = 14
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] mic_in,
    input  logic [SAMPLE_W-1:0] thr_in,
    output logic [FREQ_W-1:0]   freq,
    output bcd_digit_t          dig_0,
    output bcd_digit_t          dig_1,
    output bcd_digit_t          dig_2,
    output bcd_digit_t          dig_3,
    output logic                freq_valid,
    output logic                overflow,
    output logic                busy,
    output logic [SAMPLE_W-1:0] thr_out
);

    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned CNT_W  = $clog2(GATE_SAMPLES + 1);
    localparam int unsigned SMAX   = (1 << SAMPLE_W) - 1;

    if (SAMPLE_DIV * GATE_SAMPLES <= FREQ_W + 4) begin : g_bad_params
        $error("freq_meter: gate window shorter than conversion latency");
    end

    // Sample strobe
    logic [DIV_W-1:0] r_div;
    logic             w_strobe;

    assign w_strobe = (r_div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (reset || w_strobe) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Threshold selection
    logic [SAMPLE_W-1:0] w_thr;
    logic [CNT_W-1:0]    r_smp;
    logic                w_close;

    assign w_close = w_strobe && (r_smp == CNT_W'(GATE_SAMPLES - 1));

`ifdef FREQ_METER_AUTOTHRESH_EN
    logic [SAMPLE_W-1:0] r_thr;
    logic [SAMPLE_W-1:0] r_min;
    logic [SAMPLE_W-1:0] r_max;
    logic [SAMPLE_W-1:0] w_min_cur;
    logic [SAMPLE_W-1:0] w_max_cur;
    logic [SAMPLE_W:0]   w_sum;
    logic                w_unused_thr;

    // Running extremes including the current sample; the first sample of a
    // window re-seeds both.
    always_comb begin
        w_min_cur = r_min;
        w_max_cur = r_max;
        if (r_smp == '0 || mic_in < r_min) w_min_cur = mic_in;
        if (r_smp == '0 || mic_in > r_max) w_max_cur = mic_in;
    end

    assign w_sum        = {1'b0, w_max_cur} + {1'b0, w_min_cur};
    assign w_unused_thr = ^thr_in;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_thr <= SAMPLE_W'(THR_DEFAULT);
            r_min <= '0;
            r_max <= '0;
        end else if (w_strobe) begin
            r_min <= w_min_cur;
            r_max <= w_max_cur;
            if (w_close && (32'(w_max_cur - w_min_cur) >= MIN_SWING)) begin
                r_thr <= w_sum[SAMPLE_W:1];
            end
        end
    end

    assign w_thr = r_thr;
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = THR_DEFAULT ^ MIN_SWING;
    assign w_thr        = thr_in;
`endif

    assign thr_out = w_thr;

    // Hysteresis band, saturating at both rails
    logic [31:0]         w_hi_sum;
    logic [SAMPLE_W-1:0] w_thr_hi;
    logic [SAMPLE_W-1:0] w_thr_lo;

    assign w_hi_sum = 32'(w_thr) + HYST;
    assign w_thr_hi = (w_hi_sum > SMAX) ? {SAMPLE_W{1'b1}} : w_hi_sum[SAMPLE_W-1:0];
    assign w_thr_lo = (32'(w_thr) >= HYST) ? SAMPLE_W'(32'(w_thr) - HYST) : '0;

    // Crossing detector and gate
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_snap;
    logic             w_cross;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_cross    = r_armed && (mic_in >= w_thr_hi);
    assign w_cnt_next = (w_cross && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_smp   <= '0;
            r_snap  <= '0;
        end else if (w_strobe) begin
            if (w_cross) begin
                r_armed <= 1'b0;
            end else if (mic_in <= w_thr_lo) begin
                r_armed <= 1'b1;
            end
            if (w_close) begin
                // Snapshot includes a crossing on the closing sample itself.
                r_snap <= w_cnt_next;
                r_cnt  <= '0;
                r_smp  <= '0;
            end else begin
                r_cnt <= w_cnt_next;
                r_smp <= r_smp + CNT_W'(1);
            end
        end
    end

    // Scaling and clamp
    logic [31:0]       w_prod;
    logic [31:0]       w_res32;
    logic              w_ovf;
    logic [FREQ_W-1:0] w_result;

    assign w_prod   = 32'(r_snap) * SCALE;
    assign w_res32  = (w_prod != '0) ? w_prod + FREQ_OFFSET : w_prod;
    assign w_ovf    = (w_res32 > MAX_DISPLAY);
    assign w_result = w_ovf ? FREQ_W'(MAX_DISPLAY) : FREQ_W'(w_res32);

    // BCD conversion
    fsm_state_e                r_state;
    logic                      w_bcd_done;
    logic [4*BCD_DIGITS-1:0]   w_bcd;

    bin2bcd_seq #(
        .BIN_W (FREQ_W)
    ) u_bin2bcd (
        .i_clk   (CLK100MHZ),
        .i_rst   (reset),
        .i_start (r_state == StScale),
        .i_bin   (w_result),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    // Conversion FSM with registered outputs
    logic [FREQ_W-1:0]       r_result;
    logic                    r_ovf_next;
    logic [FREQ_W-1:0]       r_freq;
    logic [4*BCD_DIGITS-1:0] r_dig;
    logic                    r_freq_valid;
    logic                    r_overflow;
    logic                    r_busy;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state      <= StIdle;
            r_result     <= '0;
            r_ovf_next   <= 1'b0;
            r_freq       <= '0;
            r_dig        <= '0;
            r_freq_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_close) begin
                        r_state <= StScale;
                        r_busy  <= 1'b1;
                    end
                end
                StScale: begin
                    r_result   <= w_result;
                    r_ovf_next <= w_ovf;
                    r_state    <= StConv;
                end
                StConv: begin
                    if (w_bcd_done) begin
                        r_freq       <= r_result;
                        r_dig        <= w_bcd;
                        r_overflow   <= r_ovf_next;
                        r_freq_valid <= 1'b1;
                        r_state      <= StPub;
                    end
                end
                StPub: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign freq       = r_freq;
    assign dig_0      = r_dig[3:0];
    assign dig_1      = r_dig[7:4];
    assign dig_2      = r_dig[11:8];
    assign dig_3      = r_dig[15:12];
    assign freq_valid = r_freq_valid;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (SCALE=2 and SCALE=200) share one
// sample stream; a behavioural model predicts every publish.
module tb_freq_meter;

    localparam int unsigned DIV   = 4;
    localparam int unsigned GATE  = 100;
    localparam int unsigned HY    = 64;
    localparam int unsigned THRD  = 2150;
    localparam int unsigned MINSW = 256;
    localparam int unsigned LAT   = 15;  // close-strobe edge to publish cycle

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mic_in = '0;
    logic [11:0] thr_in = 12'd2048;

    logic [13:0] freq_a, freq_b;
    logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    logic        valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;
    logic [11:0] thr_a, thr_b;

    always #5 clk = ~clk;

    freq_meter #(
        .SAMPLE_W(12), .SAMPLE_DIV(DIV), .GATE_SAMPLES(GATE), .SCALE(2),
        .FREQ_OFFSET(0), .HYST(HY), .THR_DEFAULT(THRD), .MIN_SWING(MINSW), .FREQ_W(14)
    ) dut_a (
        .CLK100MHZ(clk), .reset(reset), .mic_in(mic_in), .thr_in(thr_in),
        .freq(freq_a), .dig_0(a0), .dig_1(a1), .dig_2(a2), .dig_3(a3),
        .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a), .thr_out(thr_a)
    );

    freq_meter #(
        .SAMPLE_W(12), .SAMPLE_DIV(DIV), .GATE_SAMPLES(GATE), .SCALE(200),
        .FREQ_OFFSET(0), .HYST(HY), .THR_DEFAULT(THRD), .MIN_SWING(MINSW), .FREQ_W(14)
    ) dut_b (
        .CLK100MHZ(clk), .reset(reset), .mic_in(mic_in), .thr_in(thr_in),
        .freq(freq_b), .dig_0(b0), .dig_1(b1), .dig_2(b2), .dig_3(b3),
        .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b), .thr_out(thr_b)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned fa;
        bit          oa;
        int unsigned fb;
        bit          ob;
    } pub_t;

    pub_t        q[$];
    int unsigned cyc = 0;
    bit          checking = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Model state
    bit          m_armed = 1'b0;
    int unsigned m_cnt = 0;
    int unsigned m_n = 0;
    int unsigned m_thr = 2048;
    int unsigned m_min = 0;
    int unsigned m_max = 0;

    // Expected held outputs
    int unsigned e_fa = 0, e_fb = 0;
    bit          e_oa = 1'b0, e_ob = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned dig(input int unsigned n, input int unsigned i);
        int unsigned v;
        v = n;
        for (int k = 0; k < int'(i); k++) v = v / 10;
        return v % 10;
    endfunction

    function automatic int unsigned clamp(input int unsigned n);
        return (n > 9999) ? 9999 : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        e_fa = 0; e_fb = 0; e_oa = 1'b0; e_ob = 1'b0;
        m_armed = 1'b0; m_cnt = 0; m_n = 0; m_min = 0; m_max = 0;
`ifdef FREQ_METER_AUTOTHRESH_EN
        m_thr = THRD;
`else
        m_thr = 32'(thr_in);
`endif
    endtask

    // Drive one sample for a full strobe period, then apply the spec rules.
    task automatic send(input int unsigned v);
        int unsigned hi, lo;
        pub_t        p;
        mic_in = v[11:0];
        repeat (DIV) tick();
        hi = (m_thr + HY > 4095) ? 4095 : m_thr + HY;
        lo = (m_thr >= HY) ? m_thr - HY : 0;
        if (m_armed && v >= hi) begin
            m_armed = 1'b0;
            m_cnt++;
        end else if (v <= lo) begin
            m_armed = 1'b1;
        end
        if (m_n == 0) begin
            m_min = v; m_max = v;
        end else begin
            if (v < m_min) m_min = v;
            if (v > m_max) m_max = v;
        end
        m_n++;
        if (m_n == GATE) begin
            p.cyc = cyc + LAT;
            p.fa  = clamp(m_cnt * 2);
            p.oa  = (m_cnt * 2 > 9999);
            p.fb  = clamp(m_cnt * 200);
            p.ob  = (m_cnt * 200 > 9999);
            q.push_back(p);
`ifdef FREQ_METER_AUTOTHRESH_EN
            if (m_max - m_min >= MINSW) m_thr = (m_max + m_min) / 2;
`endif
            m_cnt = 0;
            m_n = 0;
        end
    endtask

    // Sample i of the stream is a when (i/len) is even, else b.
    task automatic wave(input int unsigned a, input int unsigned b, input int unsigned len,
                        input int unsigned start, input int unsigned count);
        int unsigned idx;
        for (int i = 0; i < int'(count); i++) begin
            idx = start + 32'(i);
            send(((idx / len) % 2 == 0) ? a : b);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit e_valid, e_busy;
        if (checking) begin
            e_busy  = (q.size() > 0) && (cyc + LAT >= q[0].cyc);
            e_valid = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e_fa = q[0].fa; e_oa = q[0].oa; e_fb = q[0].fb; e_ob = q[0].ob;
                e_valid = 1'b1;
                q.delete(0);
            end
            chk("a_freq", 32'(freq_a), e_fa);
            chk("a_dig0", 32'(a0), dig(e_fa, 0));
            chk("a_dig1", 32'(a1), dig(e_fa, 1));
            chk("a_dig2", 32'(a2), dig(e_fa, 2));
            chk("a_dig3", 32'(a3), dig(e_fa, 3));
            chk("a_valid", 32'(valid_a), 32'(e_valid));
            chk("a_ovf", 32'(ovf_a), 32'(e_oa));
            chk("a_busy", 32'(busy_a), 32'(e_busy));
            chk("a_thr", 32'(thr_a), m_thr);
            chk("b_freq", 32'(freq_b), e_fb);
            chk("b_dig0", 32'(b0), dig(e_fb, 0));
            chk("b_dig1", 32'(b1), dig(e_fb, 1));
            chk("b_dig2", 32'(b2), dig(e_fb, 2));
            chk("b_dig3", 32'(b3), dig(e_fb, 3));
            chk("b_valid", 32'(valid_b), 32'(e_valid));
            chk("b_ovf", 32'(ovf_b), 32'(e_ob));
            chk("b_busy", 32'(busy_b), 32'(e_busy));
            chk("b_thr", 32'(thr_b), m_thr);
        end
    end

    task automatic pin_outputs(input string nm, input int unsigned fa, input bit oa,
                               input int unsigned fb, input bit ob,
                               input logic [15:0] da, input logic [15:0] db);
        chk({nm, "_fa"}, 32'(freq_a), fa);
        chk({nm, "_oa"}, 32'(ovf_a), 32'(oa));
        chk({nm, "_da"}, 32'({a3, a2, a1, a0}), 32'(da));
        chk({nm, "_fb"}, 32'(freq_b), fb);
        chk({nm, "_ob"}, 32'(ovf_b), 32'(ob));
        chk({nm, "_db"}, 32'({b3, b2, b1, b0}), 32'(db));
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        model_reset();
        reset = 1'b0;
        checking = 1'b1;
        pin_outputs("rst", 0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);

`ifdef FREQ_METER_AUTOTHRESH_EN
        chk("rst_thr", 32'(thr_a), 2150);
        wave(500, 1500, 10, 0, 100);
        wave(500, 1500, 10, 0, 8);
        pin_outputs("auto1", 0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);
        chk("auto1_thr", 32'(thr_a), 1000);
        wave(500, 1500, 10, 8, 92);
        wave(1000, 3000, 10, 0, 8);
        pin_outputs("auto2", 10, 1'b0, 1000, 1'b0, 16'h0010, 16'h1000);
        wave(1000, 3000, 10, 8, 92);
`else
        wave(1000, 3000, 10, 0, 100);
`endif

        // 50 crossings; the last one lands on the closing sample
        wave(1000, 3000, 1, 0, 8);
`ifndef FREQ_METER_AUTOTHRESH_EN
        pin_outputs("square", 10, 1'b0, 1000, 1'b0, 16'h0010, 16'h1000);
`endif
        wave(1000, 3000, 1, 8, 92);

        // Inside the hysteresis band; also shows the count restarted at 0
        wave(2060, 2040, 1, 0, 8);
        pin_outputs("sat", 100, 1'b0, 9999, 1'b1, 16'h0100, 16'h9999);
        wave(2060, 2040, 1, 8, 92);

        wave(1000, 3000, 10, 0, 8);
        pin_outputs("band", 0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);
        wave(1000, 3000, 10, 8, 92);

        // Abort the pending conversion with a reset 5 cycles after close
        repeat (5) tick();
        reset = 1'b1;
        tick();
        model_reset();
        reset = 1'b0;
        pin_outputs("abort", 0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);
        chk("abort_busy", 32'(busy_a), 0);

        wave(1000, 3000, 10, 0, 100);
        wave(2048, 2048, 1, 0, 8);
        pin_outputs("post", 10, 1'b0, 1000, 1'b0, 16'h0010, 16'h1000);
        chk("post_queue", 32'(q.size()), 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
